// File: rtl/uio_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uio_arb_pkg
// Description : Shared types and constants for the uio pad-bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TURN  = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } arb_state_e;

    localparam logic       DIR_WR = 1'b1;
    localparam logic       DIR_RD = 1'b0;
    localparam logic [7:0] OE_ON  = 8'hFF;
    localparam logic [7:0] OE_OFF = 8'h00;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Round-robin picker: first set request at or after ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [2:0]       idx,
    output logic             valid
);

    always_comb begin
        onehot = '0;
        idx    = 3'd0;
        valid  = 1'b0;
        // Masked pass first (indices >= ptr), then the wrap-around pass.
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j] && (3'(j) >= ptr)) begin
                onehot[j] = 1'b1;
                idx       = 3'(j);
                valid     = 1'b1;
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!valid && req[j]) begin
                onehot[j] = 1'b1;
                idx       = 3'(j);
                valid     = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uio_bus_arbiter
// Description : Round-robin arbiter sharing the 8-bit uio pad bus, one byte/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     dir,
    input  logic [N_REQ-1:0]     last,
    input  logic [8*N_REQ-1:0]   wdata,
    input  logic [7:0]           uio_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [7:0]           uio_out,
    output logic [7:0]           uio_oe,
    output logic [7:0]           rdata,
    output logic                 rvalid,
    output logic [2:0]           rid,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] c_cnt_cap = CNT_W'(MAX_BURST - 1);

    arb_state_e        r_state;
    logic [2:0]        r_rr_ptr;
    logic              r_last_dir;
    logic              r_dir;
    logic [2:0]        r_cur;
    logic [N_REQ-1:0]  r_cur_oh;
    logic [CNT_W-1:0]  r_byte_cnt;

    logic [N_REQ-1:0]  w_pick_oh;
    logic [2:0]        w_pick_idx;
    logic              w_pick_valid;
    logic              w_pick_dir;
    logic [2:0]        w_next_ptr;
    logic              w_cur_req;
    logic              w_cur_last;
    logic [7:0]        w_wsel;
    logic              w_end;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req    (req),
        .ptr    (r_rr_ptr),
        .onehot (w_pick_oh),
        .idx    (w_pick_idx),
        .valid  (w_pick_valid)
    );

    assign w_pick_dir = |(dir & w_pick_oh);
    assign w_next_ptr = (w_pick_idx == 3'(N_REQ - 1)) ? 3'd0 : w_pick_idx + 3'd1;
    assign w_cur_req  = |(req & r_cur_oh);
    assign w_cur_last = |(last & r_cur_oh);
    assign w_end      = !w_cur_req || w_cur_last || (r_byte_cnt == c_cnt_cap);

    always_comb begin
        w_wsel = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            w_wsel = w_wsel | (wdata[8*i +: 8] & {8{r_cur_oh[i]}});
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            gnt        <= '0;
            uio_out    <= 8'h00;
            uio_oe     <= OE_OFF;
            rdata      <= 8'h00;
            rvalid     <= 1'b0;
            rid        <= 3'd0;
            busy       <= 1'b0;
            r_rr_ptr   <= 3'd0;
            r_last_dir <= DIR_RD;
            r_dir      <= DIR_RD;
            r_cur      <= 3'd0;
            r_cur_oh   <= '0;
            r_byte_cnt <= '0;
        end else if (!ena) begin
            r_state <= IDLE;
            gnt     <= '0;
            uio_oe  <= OE_OFF;
            rvalid  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    uio_oe     <= OE_OFF;
                    gnt        <= '0;
                    r_byte_cnt <= '0;
                    busy       <= w_pick_valid;
                    if (w_pick_valid) begin
                        r_cur    <= w_pick_idx;
                        r_cur_oh <= w_pick_oh;
                        r_dir    <= w_pick_dir;
                        r_rr_ptr <= w_next_ptr;
                        if (w_pick_dir != r_last_dir) begin
                            r_state <= TURN;
                        end else begin
                            r_state <= XFER;
                            gnt     <= w_pick_oh;
                        end
                    end
                end
                TURN: begin
                    uio_oe     <= OE_OFF;
                    r_last_dir <= r_dir;
                    r_state    <= XFER;
                    gnt        <= r_cur_oh;
                end
                XFER: begin
                    // An aborting cycle (req dropped) moves no byte.
                    if (w_cur_req) begin
                        r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                        if (r_dir == DIR_WR) begin
                            uio_out <= w_wsel;
                            uio_oe  <= OE_ON;
                        end else begin
                            rdata  <= uio_in;
                            rid    <= r_cur;
                            rvalid <= 1'b1;
                        end
                    end
                    if (w_end) begin
                        r_state <= DRAIN;
                        gnt     <= '0;
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    gnt     <= '0;
                    uio_oe  <= OE_OFF;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uio_bus_arbiter
// Description : Directed self-checking bench for uio_bus_arbiter (N_REQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uio_bus_arbiter;

    localparam int N = 4;

    logic           clk;
    logic           rst_n;
    logic           ena;
    logic [N-1:0]   req;
    logic [N-1:0]   dir;
    logic [N-1:0]   last;
    logic [8*N-1:0] wdata;
    logic [7:0]     uio_in;
    logic [N-1:0]   gnt;
    logic [7:0]     uio_out;
    logic [7:0]     uio_oe;
    logic [7:0]     rdata;
    logic           rvalid;
    logic [2:0]     rid;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    uio_bus_arbiter #(.N_REQ(N), .MAX_BURST(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .dir     (dir),
        .last    (last),
        .wdata   (wdata),
        .uio_in  (uio_in),
        .gnt     (gnt),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .rid     (rid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One posedge passes; returns at the following negedge for sampling.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        dir   = '0;
        ena   = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Wait (bounded) for any grant; reports a timeout as a failed comparison.
    task automatic wait_gnt(input string tag);
        int c;
        c = 0;
        while (gnt == '0 && c < 12) begin
            step();
            c++;
        end
        if (gnt == '0) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    logic [N-1:0] rr_exp [5];
    int           hi_cnt;

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = 4'hF;
        dir    = 4'hF;
        last   = '0;
        wdata  = '0;
        uio_in = 8'h00;

        // Reset held two cycles with all requests high
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_gnt",  32'(gnt),    32'h0);
            check("rst_oe",   32'(uio_oe), 32'h0);
            check("rst_busy", 32'(busy),   32'h0);
        end
        check("rst_rvalid", 32'(rvalid), 32'h0);
        req   = '0;
        dir   = '0;
        step();
        rst_n = 1'b1;

        // Single write by requester 1: TURN, A5, 3C
        req           = 4'b0010;
        dir           = 4'b0010;
        wdata[15:8]   = 8'hA5;
        step();
        check("wr_turn_gnt",  32'(gnt),    32'h0);
        check("wr_turn_oe",   32'(uio_oe), 32'h0);
        check("wr_turn_busy", 32'(busy),   32'h1);
        step();
        check("wr_xfer_gnt",  32'(gnt),    32'h2);
        check("wr_xfer_oe",   32'(uio_oe), 32'h0);
        step();
        check("wr_b0_out",    32'(uio_out), 32'hA5);
        check("wr_b0_oe",     32'(uio_oe),  32'hFF);
        wdata[15:8] = 8'h3C;
        last        = 4'b0010;
        step();
        check("wr_b1_out",    32'(uio_out), 32'h3C);
        check("wr_b1_oe",     32'(uio_oe),  32'hFF);
        check("wr_drain_gnt", 32'(gnt),     32'h0);
        req  = '0;
        last = '0;
        step();
        check("wr_idle_oe",   32'(uio_oe),  32'hFF);
        check("wr_idle_out",  32'(uio_out), 32'h3C);
        check("wr_idle_busy", 32'(busy),    32'h0);
        step();
        check("wr_oe_off",    32'(uio_oe),  32'h0);

        // Read by requester 2 straight after reset: no TURN
        do_reset();
        req    = 4'b0100;
        dir    = 4'b0000;
        step();
        check("rd_gnt", 32'(gnt), 32'h4);
        uio_in = 8'h11;
        step();
        check("rd_v0",    32'(rvalid), 32'h1);
        check("rd_d0",    32'(rdata),  32'h11);
        check("rd_rid",   32'(rid),    32'h2);
        check("rd_oe",    32'(uio_oe), 32'h0);
        uio_in = 8'h22;
        step();
        check("rd_v1",    32'(rvalid), 32'h1);
        check("rd_d1",    32'(rdata),  32'h22);
        uio_in = 8'h33;
        last   = 4'b0100;
        step();
        check("rd_v2",    32'(rvalid), 32'h1);
        check("rd_d2",    32'(rdata),  32'h33);
        check("rd_drain_gnt", 32'(gnt), 32'h0);
        req  = '0;
        last = '0;
        step();
        check("rd_v_end", 32'(rvalid), 32'h0);
        check("rd_busy",  32'(busy),   32'h0);

        // Round-robin with single-byte bursts from everyone
        do_reset();
        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;
        req  = 4'hF;
        last = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_gnt("rr");
            check($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
            step();
        end
        req  = '0;
        last = '0;
        step();
        step();

        // Burst cap: requester 0 never signals last
        do_reset();
        req = 4'b0001;
        wait_gnt("cap");
        hi_cnt = 0;
        while (gnt[0] && hi_cnt < 40) begin
            hi_cnt++;
            step();
        end
        check("cap_len", 32'(hi_cnt), 32'd16);
        check("cap_busy_drain", 32'(busy), 32'h1);
        req = '0;
        step();
        step();

        // Abort mid-write, then resume from retained rr_ptr (=2)
        do_reset();
        req         = 4'b0010;
        dir         = 4'b0010;
        wdata[15:8] = 8'h5A;
        step();
        step();
        step();
        check("ab_pre_oe", 32'(uio_oe), 32'hFF);
        ena = 1'b0;
        step();
        check("ab_oe",     32'(uio_oe), 32'h0);
        check("ab_gnt",    32'(gnt),    32'h0);
        check("ab_busy",   32'(busy),   32'h0);
        check("ab_rvalid", 32'(rvalid), 32'h0);
        ena = 1'b1;
        req = 4'b1010;
        dir = 4'b0000;
        wait_gnt("ab_resume");
        check("ab_resume_gnt", 32'(gnt), 32'h8);
        req = '0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
